// File: rtl/iot_active_monitor_mc.sv
`default_nettype none
// ============================================================================
// Module   : iot_active_monitor_mc
// Brief    : Multi-channel connected-device counter. Keeps a total, a peak
//            hold, a high-watermark alarm and sticky over/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module iot_active_monitor_mc #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_CH    = 4,
    parameter int               CH_W      = $clog2(NUM_CH),
    parameter int               TOT_W     = WIDTH + CH_W,
    parameter int               SATURATE  = 1,
    parameter logic [TOT_W-1:0] HI_THRESH = TOT_W'(16)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ev_valid,
    input  logic [CH_W-1:0]  ev_ch,
    input  logic             ev_up,
    input  logic             clr_valid,
    input  logic [CH_W-1:0]  clr_ch,
    input  logic             err_clr,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [WIDTH-1:0] rd_count,
    output logic [TOT_W-1:0] total,
    output logic [TOT_W-1:0] peak,
    output logic             alarm_hi,
    output logic             err_over,
    output logic             err_under
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt     [NUM_CH];
    logic [WIDTH-1:0] w_cnt_nxt [NUM_CH];
    logic [TOT_W-1:0] r_total;
    logic [TOT_W-1:0] r_peak;
    logic             r_alarm;
    logic             r_err_over;
    logic             r_err_under;
    logic [TOT_W-1:0] w_tot_nxt;
    logic             w_ev_acc;
    logic             w_set_over;
    logic             w_set_under;

    assign w_ev_acc = ev_valid & en;

    // A clear on the event's channel takes precedence and suppresses its error.
    always_comb begin
        w_set_over  = 1'b0;
        w_set_under = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (clr_valid && (clr_ch == CH_W'(i))) begin
                w_cnt_nxt[i] = '0;
            end else if (w_ev_acc && (ev_ch == CH_W'(i))) begin
                if (ev_up) begin
                    if (r_cnt[i] == c_max) begin
                        w_set_over   = 1'b1;
                        w_cnt_nxt[i] = (SATURATE != 0) ? c_max : '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
                    end
                end else begin
                    if (r_cnt[i] == '0) begin
                        w_set_under  = 1'b1;
                        w_cnt_nxt[i] = (SATURATE != 0) ? '0 : c_max;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_tot_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_tot_nxt = w_tot_nxt + TOT_W'(w_cnt_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_total     <= '0;
            r_peak      <= '0;
            r_alarm     <= 1'b0;
            r_err_over  <= 1'b0;
            r_err_under <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_total <= w_tot_nxt;
            if (w_tot_nxt > r_peak) begin
                r_peak <= w_tot_nxt;
            end
            r_alarm <= (w_tot_nxt >= HI_THRESH);
            // A new error in the same cycle as err_clr keeps the flag set.
            if (w_set_over) begin
                r_err_over <= 1'b1;
            end else if (err_clr) begin
                r_err_over <= 1'b0;
            end
            if (w_set_under) begin
                r_err_under <= 1'b1;
            end else if (err_clr) begin
                r_err_under <= 1'b0;
            end
        end
    end

    assign rd_count  = r_cnt[rd_ch];
    assign total     = r_total;
    assign peak      = r_peak;
    assign alarm_hi  = r_alarm;
    assign err_over  = r_err_over;
    assign err_under = r_err_under;

endmodule
`default_nettype wire
